// File: rtl/axi_default_slave_wr.sv
//------------------------------------------------------------------------------
// axi_default_slave_wr
//
// Write-side responder of the AXI default slave. Terminates any write that the
// interconnect could not decode: accepts one AW address, swallows every W beat
// of the burst (count taken from AWLEN) and returns a single B response that
// carries the captured AWID and a fixed error code. One transaction at a time.
//
// Ports
//   ACLK, ARESET         clock (rising edge) and asynchronous active-high reset
//   AW*_SD               write address channel; only AWID and AWLEN are used
//   W*_SD                write data channel; data/strobes are discarded,
//                        WLAST is only cross-checked against the beat count
//   B*_SD                write response channel; BID/BRESP read 0 when idle
//   wlast_err            one-cycle pulse per beat whose WLAST disagrees with
//                        the beat count derived from AWLEN
//------------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_default_slave_wr #(
    parameter logic [1:0] RESP_CODE = 2'b11
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [`AXI_IDS_BITS-1:0]    AWID_SD,
    input  logic [`AXI_ADDR_BITS-1:0]   AWADDR_SD,
    input  logic [`AXI_LEN_BITS-1:0]    AWLEN_SD,
    input  logic [`AXI_SIZE_BITS-1:0]   AWSIZE_SD,
    input  logic [1:0]                  AWBURST_SD,
    input  logic                        AWVALID_SD,
    output logic                        AWREADY_SD,
    input  logic [`AXI_DATA_BITS-1:0]   WDATA_SD,
    input  logic [`AXI_STRB_BITS-1:0]   WSTRB_SD,
    input  logic                        WLAST_SD,
    input  logic                        WVALID_SD,
    output logic                        WREADY_SD,
    output logic [`AXI_IDS_BITS-1:0]    BID_SD,
    output logic [1:0]                  BRESP_SD,
    output logic                        BVALID_SD,
    input  logic                        BREADY_SD,
    output logic                        wlast_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [`AXI_IDS_BITS-1:0]    id_q, id_d;
    logic [`AXI_LEN_BITS-1:0]    len_q, len_d;
    logic [`AXI_LEN_BITS-1:0]    cnt_q, cnt_d;
    logic                        wlast_err_q, wlast_err_d;

    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic last_beat_s;

    // Address, data and strobe contents are deliberately not looked at.
    logic unused_s;
    assign unused_s = ^{AWADDR_SD, AWSIZE_SD, AWBURST_SD, WDATA_SD, WSTRB_SD};

    // Channel handshakes; readies come straight from the registered state.
    assign aw_hs_s     = AWVALID_SD & AWREADY_SD;
    assign w_hs_s      = WVALID_SD & WREADY_SD;
    assign b_hs_s      = BVALID_SD & BREADY_SD;
    assign last_beat_s = (cnt_q == len_q);

    assign AWREADY_SD = (state_q == ST_IDLE);
    assign WREADY_SD  = (state_q == ST_DATA);
    assign BVALID_SD  = (state_q == ST_RESP);
    // Response fields are masked to zero outside the response phase.
    assign BID_SD     = (state_q == ST_RESP) ? id_q : {`AXI_IDS_BITS{1'b0}};
    assign BRESP_SD   = (state_q == ST_RESP) ? RESP_CODE : 2'b00;
    assign wlast_err  = wlast_err_q;

    // Next-state logic: burst length is decided by the beat counter alone.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wlast_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    id_d    = AWID_SD;
                    len_d   = AWLEN_SD;
                    cnt_d   = {`AXI_LEN_BITS{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_hs_s) begin
                    // WLAST only raises a flag; it never shortens or extends the burst.
                    wlast_err_d = (WLAST_SD != last_beat_s);
                    if (last_beat_s) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q + {{(`AXI_LEN_BITS-1){1'b0}}, 1'b1};
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (b_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers, cleared by the asynchronous reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            id_q        <= {`AXI_IDS_BITS{1'b0}};
            len_q       <= {`AXI_LEN_BITS{1'b0}};
            cnt_q       <= {`AXI_LEN_BITS{1'b0}};
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wlast_err_q <= wlast_err_d;
        end
    end

endmodule
